// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: windowed spike-rate and last inter-spike-interval decoder with a valid/ready record output
module spike_rate_decoder #(
  parameter int WINDOW = 256,
  parameter int ISI_W  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             spike,
  output logic [7:0]       rate_out,
  output logic [ISI_W-1:0] isi_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);
  typedef enum logic {EMPTY, FULL} state_t;
  localparam logic [15:0] WLAST = 16'(WINDOW - 1);
  localparam logic [ISI_W-1:0] IMAX = '1;
  state_t state, state_nx;
  logic [15:0] wcnt;
  logic [7:0] scnt, scnt_nx;
  logic [ISI_W-1:0] icnt, icnt_inc, isi_last, isi_nx;
  logic seen, hit, close, load, drop;
  // Next-cycle values include the current cycle's spike so a close-cycle spike lands in the record
  always_comb begin
    hit = en && spike;
    close = en && wcnt == WLAST;
    icnt_inc = icnt == IMAX ? IMAX : icnt + 1'b1;
    scnt_nx = hit && scnt != 8'hff ? scnt + 8'd1 : scnt;
    isi_nx = hit && seen ? icnt_inc : isi_last;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
      scnt <= '0;
      icnt <= '0;
      isi_last <= '0;
      seen <= 1'b0;
    end else if (en) begin
      wcnt <= close ? '0 : wcnt + 16'd1;
      scnt <= close ? '0 : scnt_nx;
      icnt <= hit ? '0 : icnt_inc;
      isi_last <= isi_nx;
      seen <= seen | spike;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else state <= state_nx;
  end
  always_comb state_nx = close ? FULL : (state == FULL && out_ready) ? EMPTY : state;
  always_comb begin
    out_valid = state == FULL;
    load = close && (state == EMPTY || out_ready);
    drop = close && state == FULL && !out_ready;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_out <= '0;
      isi_out <= '0;
      overrun <= 1'b0;
    end else begin
      if (load) begin
        rate_out <= scnt_nx;
        isi_out <= isi_nx;
      end
      if (drop) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: scenario tasks with a queue of expected records for WINDOW=16 and WINDOW=300 instances
module tb_spike_rate_decoder;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, spike = 1'b0, out_ready = 1'b0;
  logic [7:0] r16, r300;
  logic [11:0] i16, i300;
  logic v16, v300, o16, o300;
  int n_cmp = 0, n_bad = 0;
  typedef struct {logic [7:0] rate; logic [11:0] isi;} rec_t;
  rec_t exp_q[$];
  rec_t e;
  always #5 clk = ~clk;
  spike_rate_decoder #(.WINDOW(16), .ISI_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .spike(spike), .rate_out(r16), .isi_out(i16),
    .out_valid(v16), .out_ready(out_ready), .overrun(o16)
  );
  spike_rate_decoder #(.WINDOW(300), .ISI_W(12)) dut300 (
    .clk(clk), .rst_n(rst_n), .en(en), .spike(spike), .rate_out(r300), .isi_out(i300),
    .out_valid(v300), .out_ready(out_ready), .overrun(o300)
  );
  task automatic step(input logic e_i, input logic s_i, input logic r_i);
    en = e_i;
    spike = s_i;
    out_ready = r_i;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    rst_n = 1'b1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_cmp++;
      if ({r16, i16, v16, o16, r300, i300, v300, o300} !== 44'd0) begin
        n_bad++;
        $display("FAIL reset_outputs: got %h want 0", {r16, i16, v16, o16, r300, i300, v300, o300});
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      step(1, 0, 0);
      if (c == 14) begin
        n_cmp++;
        if (v16 !== 1'b0) begin n_bad++; $display("FAIL reset_early_valid: got %b want 0", v16); end
      end
    end
    exp_q.push_back('{8'd0, 12'd0});
    n_cmp++;
    if (v16 !== 1'b1) begin n_bad++; $display("FAIL reset_first_valid: got %b want 1", v16); end
    e = exp_q.pop_front();
    n_cmp++;
    if ({r16, i16} !== {e.rate, e.isi}) begin n_bad++; $display("FAIL reset_record: got %0d/%0d want %0d/%0d", r16, i16, e.rate, e.isi); end
    step(0, 0, 1);
    n_cmp++;
    if (v16 !== 1'b0) begin n_bad++; $display("FAIL reset_consume: got %b want 0", v16); end
  endtask
  task automatic test_basic;
    do_reset();
    for (int c = 0; c < 16; c++) step(1, c % 4 == 3, 1);
    exp_q.push_back('{8'd4, 12'd4});
    n_cmp++;
    if (v16 !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", v16); end
    e = exp_q.pop_front();
    n_cmp++;
    if ({r16, i16} !== {e.rate, e.isi}) begin n_bad++; $display("FAIL basic_record: got %0d/%0d want %0d/%0d", r16, i16, e.rate, e.isi); end
    step(0, 0, 1);
    n_cmp++;
    if (v16 !== 1'b0) begin n_bad++; $display("FAIL basic_pulse: got %b want 0", v16); end
  endtask
  task automatic test_back_to_back;
    do_reset();
    for (int c = 0; c < 16; c++) step(1, c == 5 || c == 9, 0);
    exp_q.push_back('{8'd2, 12'd4});
    for (int c = 0; c < 15; c++) step(1, c == 1, 0);
    e = exp_q.pop_front();
    n_cmp++;
    if ({v16, r16, i16} !== {1'b1, e.rate, e.isi}) begin n_bad++; $display("FAIL b2b_held: got %b %0d/%0d want 1 %0d/%0d", v16, r16, i16, e.rate, e.isi); end
    exp_q.push_back('{8'd2, 12'd14});
    step(1, 1, 1);
    n_cmp++;
    if ({v16, o16} !== 2'b10) begin n_bad++; $display("FAIL b2b_flags: got valid=%b overrun=%b want 1 0", v16, o16); end
    e = exp_q.pop_front();
    n_cmp++;
    if ({r16, i16} !== {e.rate, e.isi}) begin n_bad++; $display("FAIL b2b_record: got %0d/%0d want %0d/%0d", r16, i16, e.rate, e.isi); end
    step(0, 0, 1);
  endtask
  task automatic test_overrun;
    do_reset();
    for (int c = 0; c < 16; c++) step(1, c == 2 || c == 10, 0);
    exp_q.push_back('{8'd2, 12'd8});
    n_cmp++;
    if ({v16, o16} !== 2'b10) begin n_bad++; $display("FAIL ovr_first: got valid=%b overrun=%b want 1 0", v16, o16); end
    for (int w = 0; w < 2; w++) begin
      for (int c = 0; c < 16; c++) step(1, w == 0 ? (c == 4 || c == 6) : (c == 1 || c == 14), 0);
      n_cmp++;
      if ({v16, o16, r16, i16} !== {2'b11, exp_q[0].rate, exp_q[0].isi}) begin
        n_bad++;
        $display("FAIL ovr_hold%0d: got v=%b o=%b %0d/%0d want 1 1 %0d/%0d", w, v16, o16, r16, i16, exp_q[0].rate, exp_q[0].isi);
      end
    end
    e = exp_q.pop_front();
    n_cmp++;
    if ({r16, i16} !== {e.rate, e.isi}) begin n_bad++; $display("FAIL ovr_record: got %0d/%0d want %0d/%0d", r16, i16, e.rate, e.isi); end
    step(0, 0, 1);
    n_cmp++;
    if ({v16, o16} !== 2'b01) begin n_bad++; $display("FAIL ovr_accept: got valid=%b overrun=%b want 0 1", v16, o16); end
    for (int c = 0; c < 16; c++) step(1, c == 3 || c == 9, 0);
    exp_q.push_back('{8'd2, 12'd6});
    e = exp_q.pop_front();
    n_cmp++;
    if ({v16, o16, r16, i16} !== {2'b11, e.rate, e.isi}) begin n_bad++; $display("FAIL ovr_fourth: got v=%b o=%b %0d/%0d want 1 1 %0d/%0d", v16, o16, r16, i16, e.rate, e.isi); end
    step(0, 0, 1);
  endtask
  task automatic test_gap;
    do_reset();
    for (int c = 0; c < 5; c++) step(1, c == 3, 0);
    repeat (10) step(0, 1, 0);
    for (int c = 5; c < 16; c++) begin
      step(1, c == 8, 0);
      if (c == 14) begin
        n_cmp++;
        if (v16 !== 1'b0) begin n_bad++; $display("FAIL gap_early: got %b want 0", v16); end
      end
    end
    exp_q.push_back('{8'd2, 12'd5});
    n_cmp++;
    if (v16 !== 1'b1) begin n_bad++; $display("FAIL gap_valid: got %b want 1", v16); end
    e = exp_q.pop_front();
    n_cmp++;
    if ({r16, i16} !== {e.rate, e.isi}) begin n_bad++; $display("FAIL gap_record: got %0d/%0d want %0d/%0d", r16, i16, e.rate, e.isi); end
    step(0, 0, 1);
  endtask
  task automatic test_saturate;
    do_reset();
    for (int w = 0; w < 2; w++) begin
      for (int c = 0; c < 300; c++) begin
        step(1, 1, 1);
        if (w == 1 && c == 0) begin
          n_cmp++;
          if (v300 !== 1'b0) begin n_bad++; $display("FAIL sat_consume: got %b want 0", v300); end
        end
      end
      exp_q.push_back('{8'd255, 12'd1});
      e = exp_q.pop_front();
      n_cmp++;
      if ({v300, o300, r300, i300} !== {2'b10, e.rate, e.isi}) begin
        n_bad++;
        $display("FAIL sat_window%0d: got v=%b o=%b %0d/%0d want 1 0 %0d/%0d", w, v300, o300, r300, i300, e.rate, e.isi);
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_gap();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Receive-side counterpart of the integrate-and-fire neuron: consumes the neuron's 1-bit spike train and reconstructs a rate code (spikes per fixed window) and the most recent inter-spike interval (ISI). Each result is delivered as one record over a valid/ready handshake. Sits downstream of the neuron's `spike` output, feeding readout or next-layer logic.

## Interface
- `WINDOW`, 256: window length in enabled cycles; legal range 2..65535.
- `ISI_W`, 12: ISI counter and output width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  enable; when 0, the window, spike and ISI counters freeze and `spike` is ignored.
- `spike`  in  1  spike event; every enabled cycle with `spike`=1 counts as one event (level-sampled, no edge detection).
- `rate_out`  out  8  spikes in the closed window, saturated at 255.
- `isi_out`  out  ISI_W  last measured ISI at window close; 0 = fewer than two spikes since reset.
- `out_valid`  out  1  record in `rate_out`/`isi_out` is valid.
- `out_ready`  in  1  consumer accepts the record.
- `overrun`  out  1  sticky; a window result was dropped. Cleared only by reset.

## Operation
- Window counter `wcnt`, 16 bits, runs 0..WINDOW-1, incrementing on each enabled cycle.
- Close cycle: enabled cycle with `wcnt`=WINDOW-1.
  - `wcnt` wraps to 0.
  - Spike count clears to 0.
  - The result includes the close cycle's own spike.
- Spike count `scnt`, 8 bits: on an enabled cycle with `spike`=1, `scnt` <= min(`scnt`+1, 255).
- ISI counter `icnt`, ISI_W bits, reset value 0; a flag `seen` records that at least one spike has occurred.
  - Enabled cycle with `spike`=1:
    - If `seen`=1, `isi_last` <= `icnt`+1, saturated at 2^ISI_W-1.
    - Then `icnt` <= 0 and `seen` <= 1.
  - Enabled cycle without a spike: `icnt` <= `icnt`+1, saturated at 2^ISI_W-1.
  - Result: spikes at enabled cycles t1 < t2 give ISI = t2-t1 in enabled cycles.
  - `isi_last` is not cleared at window close; it carries across windows.
- Output register, two states:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- Transitions on a close cycle:
  - From EMPTY: load the record and go to FULL.
  - From FULL with `out_ready`=1 in the same cycle: load the new record and stay FULL. The old record counts as consumed.
  - From FULL with `out_ready`=0: hold the old record, discard the new one, set `overrun`=1.
- Transitions on a non-close cycle:
  - FULL with `out_ready`=1: go to EMPTY.
- The handshake operates regardless of `en`.
- Record fields:
  - `rate_out` = `scnt` including the close-cycle spike, saturated at 255.
  - `isi_out` = `isi_last` including any update made by a close-cycle spike.
- While `out_valid`=1 and the record has not been accepted, `rate_out` and `isi_out` are stable.

## Timing
- Reset values: `rate_out`=0, `isi_out`=0, `out_valid`=0, `overrun`=0; all internal counters 0; `seen`=0; state EMPTY.
- Reset asserted mid-window discards all partial counts. After release, the first close occurs on the WINDOW-th enabled cycle.
- Latency: the record is visible and `out_valid`=1 on the cycle after the close-cycle edge, which is 1 clock.
- A handshake completes on any rising edge with `out_valid`=1 and `out_ready`=1.
- `out_ready` may be held high continuously; the module then never overruns.
- `en`=0 stretches the window by exactly the number of disabled cycles. Spikes during disabled cycles are not counted and do not affect ISI.
- Ready and valid are independent: `out_valid` does not depend combinationally on `out_ready`.

## Test plan
- Reset: drive inputs randomly with `rst_n`=0 -> all outputs 0. Release with `spike`=0 for WINDOW=16 cycles -> one record, `rate_out`=0, `isi_out`=0.
- WINDOW=16, `en`=1, spike at window cycles 3, 7, 11, 15, `out_ready`=1 -> `out_valid` pulses 1 cycle after the 16th cycle with `rate_out`=4, `isi_out`=4.
- WINDOW=300, `spike`=1 constantly -> `rate_out`=255 (saturated), `isi_out`=1. Next window identical.
- WINDOW=16, 2 spikes per window, `out_ready`=0 for 3 windows -> the first record is held unchanged and `overrun`=1 after the second close. Raise `out_ready` -> first record accepted, `out_valid`=0, then the fourth window's record appears normally; `overrun` stays 1.
- WINDOW=16, `en`=0 for 10 cycles at window cycle 5, with `spike`=1 during the gap -> close occurs 26 cycles after window start; spikes in the gap are not counted and ISI excludes the gap.
- Spike exactly on the close cycle together with `out_ready`=1 while FULL -> new record loaded with that spike counted, `out_valid` stays 1, no overrun.
